// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared encodings for the memory stage: result select, access size, FSM states
package pipeline_pkg;

  localparam logic [1:0] res_alu = 2'b00;
  localparam logic [1:0] res_mem = 2'b01;
  localparam logic [1:0] res_pc4 = 2'b10;

  localparam logic [1:0] sz_byte = 2'b00;
  localparam logic [1:0] sz_half = 2'b01;
  localparam logic [1:0] sz_word = 2'b10;

  localparam int f3_unsigned_bit = 2;

  typedef enum logic {
    st_idle,
    st_second
  } mem_state_e;

  // Access width in bytes; reserved size code 11 behaves as a word.
  function automatic logic [2:0] access_bytes(input logic [1:0] sz);
    case (sz)
      sz_byte: access_bytes = 3'd1;
      sz_half: access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] access_mask(input logic [1:0] sz);
    case (sz)
      sz_byte: access_mask = 4'b0001;
      sz_half: access_mask = 4'b0011;
      default: access_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - word-wide data memory request/response bus used by the memory stage
interface memory_stage_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/memory_stage_load_ext.sv
// rtl/memory_stage_load_ext.sv - load byte-lane select, split-beat merge and sign/zero extension
module load_ext
  import pipeline_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] hold,
  input  logic        merge,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [63:0] combined;
  logic [31:0] lane;

  // A split access presents its bytes as {second beat, first beat}; shifting
  // by the offset lines the addressed bytes up at bit 0 in both cases.
  always_comb begin
    combined = merge ? {rdata, hold} : {32'h0, rdata};
    lane     = 32'(combined >> {offset, 3'b000});
  end

  always_comb begin
    data = lane;
    case (funct3[1:0])
      sz_byte: data = funct3[f3_unsigned_bit] ? {24'h0, lane[7:0]}
                                             : {{24{lane[7]}}, lane[7:0]};
      sz_half: data = funct3[f3_unsigned_bit] ? {16'h0, lane[15:0]}
                                             : {{16{lane[15]}}, lane[15:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline M stage with MEM/WB register; MEM_SPLIT_EN enables two-beat crossing accesses
module memory_stage
  import pipeline_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 RegWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic                 MemWriteM,
  input  logic [31:0]          ALUoutM,
  input  logic [2:0]           funct3M,
  input  logic [4:0]           RdM,
  input  logic [31:0]          Rd2M,
  input  logic [31:0]          inc_PCM,

  memory_stage_if.master       mem,

  output logic                 MemStall,
  output logic                 Misalign,

  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [31:0]          ALUoutW,
  output logic [31:0]          ReadDataW,
  output logic [4:0]           RdW,
  output logic [31:0]          inc_PCW
);

  mem_state_e  state;
  logic [31:0] hold;

  logic        is_load;
  logic        memop;
  logic [1:0]  offset;
  logic [2:0]  nbytes;
  logic        crossing;
  logic        in_second;
  logic        block_cross;
  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;
  logic        handshake;
  logic        done;
  logic        advance;
  logic        misalign_now;
  logic [31:0] load_data;

  always_comb begin
    is_load   = (ResultSrcM == res_mem);
    memop     = is_load | MemWriteM;
    offset    = ALUoutM[1:0];
    nbytes    = access_bytes(funct3M[1:0]);
    crossing  = (({1'b0, offset} + nbytes) > 3'd4);
    in_second = (state == st_second);
    // The upper halves carry whatever spills past the word into the next beat.
    be_wide    = {4'b0000, access_mask(funct3M[1:0])} << offset;
    wdata_wide = {32'h0, Rd2M} << {offset, 3'b000};
  end

`ifdef MEM_SPLIT_EN
  always_comb begin
    block_cross  = 1'b0;
    misalign_now = 1'b0;
  end
`else
  always_comb begin
    block_cross  = crossing;
    misalign_now = memop & crossing;
  end
`endif

  assign mem.mem_req   = !rst && memop && !block_cross;
  assign mem.mem_we    = MemWriteM;
  assign mem.mem_addr  = {ALUoutM[31:2], 2'b00} + (in_second ? 32'd4 : 32'd0);
  assign mem.mem_be    = in_second ? be_wide[7:4] : be_wide[3:0];
  assign mem.mem_wdata = in_second ? wdata_wide[63:32] : wdata_wide[31:0];

  always_comb begin
    handshake = mem.mem_req & mem.mem_ready;
    done      = handshake & (in_second | !crossing);
    advance   = !memop | done;
    MemStall  = memop & !done & !block_cross;
  end

  load_ext u_load_ext (
    .rdata  (mem.mem_rdata),
    .hold   (hold),
    .merge  (in_second),
    .offset (offset),
    .funct3 (funct3M),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= st_idle;
      hold       <= 32'h0;
      Misalign   <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUoutW    <= 32'h0;
      ReadDataW  <= 32'h0;
      RdW        <= 5'd0;
      inc_PCW    <= 32'h0;
    end else begin
      Misalign <= misalign_now;

      if (advance) begin
        RegWriteW  <= RegWriteM;
        ResultSrcW <= ResultSrcM;
        ALUoutW    <= ALUoutM;
        ReadDataW  <= load_data;
        RdW        <= RdM;
        inc_PCW    <= inc_PCM;
      end else begin
        RegWriteW  <= 1'b0;
      end

`ifdef MEM_SPLIT_EN
      case (state)
        st_idle: begin
          if (handshake && crossing) begin
            hold  <= mem.mem_rdata;
            state <= st_second;
          end
        end
        st_second: begin
          if (handshake) begin
            state <= st_idle;
          end
        end
        default: state <= st_idle;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard bench for memory_stage: bus beats and MEM/WB writes checked by a monitor
module tb_memory_stage;
  import pipeline_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [31:0] ALUoutM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] Rd2M;
  logic [31:0] inc_PCM;
  logic        MemStall, Misalign;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUoutW, ReadDataW, inc_PCW;
  logic [4:0]  RdW;

  memory_stage_if mem_bus();

  memory_stage dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .ALUoutM    (ALUoutM),
    .funct3M    (funct3M),
    .RdM        (RdM),
    .Rd2M       (Rd2M),
    .inc_PCM    (inc_PCM),
    .mem        (mem_bus),
    .MemStall   (MemStall),
    .Misalign   (Misalign),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUoutW    (ALUoutW),
    .ReadDataW  (ReadDataW),
    .RdW        (RdW),
    .inc_PCW    (inc_PCW)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] pc;
  } wb_t;

  beat_t beat_q[$];
  wb_t   wb_q[$];
  beat_t mb;
  wb_t   mw;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] d2, input logic [31:0] pc);
    RegWriteM  = rw;
    ResultSrcM = rs;
    MemWriteM  = mw;
    ALUoutM    = a;
    funct3M    = f3;
    RdM        = rd;
    Rd2M       = d2;
    inc_PCM    = pc;
  endtask

  task automatic nop();
    drive(1'b0, res_alu, 1'b0, 32'h0, 3'b010, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic exp_beat(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    beat_t b;
    b.we = we; b.addr = a; b.be = be; b.wdata = wd;
    beat_q.push_back(b);
  endtask

  task automatic exp_wb(input logic [1:0] rs, input logic [31:0] a, input logic [31:0] rdv,
                        input logic [4:0] rd, input logic [31:0] pc);
    wb_t w;
    w.rs = rs; w.alu = a; w.rdata = rdv; w.rd = rd; w.pc = pc;
    wb_q.push_back(w);
  endtask

  // Monitor: every accepted beat and every MEM/WB write is matched against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mem_bus.mem_req && mem_bus.mem_ready) begin
        if (beat_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got addr 0x%08h be %b, none expected", mem_bus.mem_addr, mem_bus.mem_be);
        end else begin
          mb = beat_q.pop_front();
          check("beat_we", {31'h0, mem_bus.mem_we}, {31'h0, mb.we});
          check("beat_addr", mem_bus.mem_addr, mb.addr);
          check("beat_be", {28'h0, mem_bus.mem_be}, {28'h0, mb.be});
          if (mb.we) check("beat_wdata", mem_bus.mem_wdata, mb.wdata);
        end
      end
      if (!rst && RegWriteW) begin
        if (wb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_wb: got rd %0d alu 0x%08h, none expected", RdW, ALUoutW);
        end else begin
          mw = wb_q.pop_front();
          check("wb_resultsrc", {30'h0, ResultSrcW}, {30'h0, mw.rs});
          check("wb_aluout", ALUoutW, mw.alu);
          check("wb_rd", {27'h0, RdW}, {27'h0, mw.rd});
          check("wb_incpc", inc_PCW, mw.pc);
          if (mw.rs == res_mem) check("wb_readdata", ReadDataW, mw.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    nop();
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'h0;
    step(); step();
    check("reset_req", {31'h0, mem_bus.mem_req}, 32'h0);
    check("reset_regwritew", {31'h0, RegWriteW}, 32'h0);
    check("reset_aluoutw", ALUoutW, 32'h0);
    check("reset_readdataw", ReadDataW, 32'h0);
    check("reset_misalign", {31'h0, Misalign}, 32'h0);
    rst = 1'b0;
    step();

    // Aligned word load.
    drive(1'b1, res_mem, 1'b0, 32'h100, 3'b010, 5'd7, 32'h0, 32'h104);
    mem_bus.mem_rdata = 32'hDEADBEEF;
    exp_beat(1'b0, 32'h100, 4'b1111, 32'h0);
    exp_wb(res_mem, 32'h100, 32'hDEADBEEF, 5'd7, 32'h104);
    #1;
    check("lw_stall", {31'h0, MemStall}, 32'h0);
    step(); nop(); step();

    // Byte loads from the top lane, signed then unsigned.
    drive(1'b1, res_mem, 1'b0, 32'h103, 3'b000, 5'd8, 32'h0, 32'h108);
    mem_bus.mem_rdata = 32'h80112233;
    exp_beat(1'b0, 32'h100, 4'b1000, 32'h0);
    exp_wb(res_mem, 32'h103, 32'hFFFFFF80, 5'd8, 32'h108);
    step();
    drive(1'b1, res_mem, 1'b0, 32'h103, 3'b100, 5'd9, 32'h0, 32'h10C);
    exp_beat(1'b0, 32'h100, 4'b1000, 32'h0);
    exp_wb(res_mem, 32'h103, 32'h00000080, 5'd9, 32'h10C);
    step(); nop(); step();

    // Misaligned halfword store inside one word.
    drive(1'b0, res_alu, 1'b1, 32'h101, 3'b001, 5'd0, 32'h0000ABCD, 32'h110);
    exp_beat(1'b1, 32'h100, 4'b0110, 32'h00ABCD00);
    #1;
    check("sh_we", {31'h0, mem_bus.mem_we}, 32'h1);
    check("sh_stall", {31'h0, MemStall}, 32'h0);
    step(); nop();
    check("sh_no_wb", {31'h0, RegWriteW}, 32'h0);
    step();

    // Halfword loads from the upper half.
    mem_bus.mem_rdata = 32'hBEEF1234;
    drive(1'b1, res_mem, 1'b0, 32'h102, 3'b001, 5'd3, 32'h0, 32'h114);
    exp_beat(1'b0, 32'h100, 4'b1100, 32'h0);
    exp_wb(res_mem, 32'h102, 32'hFFFFBEEF, 5'd3, 32'h114);
    step();
    drive(1'b1, res_mem, 1'b0, 32'h102, 3'b101, 5'd4, 32'h0, 32'h118);
    exp_beat(1'b0, 32'h100, 4'b1100, 32'h0);
    exp_wb(res_mem, 32'h102, 32'h0000BEEF, 5'd4, 32'h118);
    step(); nop(); step();

    // Non-memory instructions with offset bits that would cross if they were loads.
    drive(1'b1, res_alu, 1'b0, 32'h00000003, 3'b010, 5'd10, 32'h0, 32'h208);
    exp_wb(res_alu, 32'h3, 32'h0, 5'd10, 32'h208);
    #1;
    check("alu_req", {31'h0, mem_bus.mem_req}, 32'h0);
    check("alu_stall", {31'h0, MemStall}, 32'h0);
    step();
    drive(1'b1, res_pc4, 1'b0, 32'h00000002, 3'b010, 5'd1, 32'h0, 32'h20C);
    exp_wb(res_pc4, 32'h2, 32'h0, 5'd1, 32'h20C);
    step(); nop();
    check("alu_misalign", {31'h0, Misalign}, 32'h0);
    step();

    // Wait states: three cycles of ready low before acceptance.
    drive(1'b1, res_mem, 1'b0, 32'h100, 3'b010, 5'd11, 32'h0, 32'h300);
    mem_bus.mem_rdata = 32'h13579BDF;
    mem_bus.mem_ready = 1'b0;
    exp_beat(1'b0, 32'h100, 4'b1111, 32'h0);
    exp_wb(res_mem, 32'h100, 32'h13579BDF, 5'd11, 32'h300);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wait_stall", {31'h0, MemStall}, 32'h1);
      check("wait_req", {31'h0, mem_bus.mem_req}, 32'h1);
      check("wait_addr", mem_bus.mem_addr, 32'h100);
      step();
      check("wait_bubble", {31'h0, RegWriteW}, 32'h0);
    end
    mem_bus.mem_ready = 1'b1;
    #1;
    check("wait_release", {31'h0, MemStall}, 32'h0);
    step(); nop(); step();

`ifdef MEM_SPLIT_EN
    // Crossing word load split into two beats.
    drive(1'b1, res_mem, 1'b0, 32'h102, 3'b010, 5'd12, 32'h0, 32'h400);
    mem_bus.mem_rdata = 32'h4433AAAA;
    exp_beat(1'b0, 32'h100, 4'b1100, 32'h0);
    exp_beat(1'b0, 32'h104, 4'b0011, 32'h0);
    exp_wb(res_mem, 32'h102, 32'h66554433, 5'd12, 32'h400);
    #1;
    check("split_stall1", {31'h0, MemStall}, 32'h1);
    step();
    mem_bus.mem_rdata = 32'hBBBB6655;
    #1;
    check("split_bubble", {31'h0, RegWriteW}, 32'h0);
    check("split_stall2", {31'h0, MemStall}, 32'h0);
    step(); nop(); step();

    // Crossing word store.
    drive(1'b0, res_alu, 1'b1, 32'h103, 3'b010, 5'd0, 32'hA1B2C3D4, 32'h404);
    exp_beat(1'b1, 32'h100, 4'b1000, 32'hD4000000);
    exp_beat(1'b1, 32'h104, 4'b0111, 32'h00A1B2C3);
    step(); step(); nop(); step();

    // Reset while waiting on the second beat.
    drive(1'b1, res_alu, 1'b0, 32'hCAFE0000, 3'b010, 5'd14, 32'h0, 32'h500);
    exp_wb(res_alu, 32'hCAFE0000, 32'h0, 5'd14, 32'h500);
    step();
    drive(1'b1, res_mem, 1'b0, 32'h102, 3'b010, 5'd13, 32'h0, 32'h504);
    mem_bus.mem_rdata = 32'h11110000;
    exp_beat(1'b0, 32'h100, 4'b1100, 32'h0);
    step();
    rst = 1'b1;
    #1;
    check("rst2_req", {31'h0, mem_bus.mem_req}, 32'h0);
    check("rst2_aluoutw", ALUoutW, 32'h0);
    check("rst2_rdw", {27'h0, RdW}, 32'h0);
    check("rst2_incpcw", inc_PCW, 32'h0);
    step();
    rst = 1'b0;
    nop();
    step();
    drive(1'b1, res_mem, 1'b0, 32'h100, 3'b010, 5'd7, 32'h0, 32'h104);
    mem_bus.mem_rdata = 32'hDEADBEEF;
    exp_beat(1'b0, 32'h100, 4'b1111, 32'h0);
    exp_wb(res_mem, 32'h100, 32'hDEADBEEF, 5'd7, 32'h104);
    #1;
    check("rst2_lw_stall", {31'h0, MemStall}, 32'h0);
    step(); nop(); step();
`else
    // Crossing access without splitting support: flagged, dropped, no stall.
    drive(1'b1, res_mem, 1'b0, 32'h102, 3'b010, 5'd15, 32'h0, 32'h600);
    #1;
    check("mis_req", {31'h0, mem_bus.mem_req}, 32'h0);
    check("mis_stall", {31'h0, MemStall}, 32'h0);
    step(); nop();
    check("mis_pulse", {31'h0, Misalign}, 32'h1);
    check("mis_bubble", {31'h0, RegWriteW}, 32'h0);
    step();
    check("mis_pulse_end", {31'h0, Misalign}, 32'h0);

    // Reset during a wait-stalled aligned load.
    drive(1'b1, res_mem, 1'b0, 32'h100, 3'b010, 5'd16, 32'h0, 32'h700);
    mem_bus.mem_ready = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("rst2_req", {31'h0, mem_bus.mem_req}, 32'h0);
    check("rst2_regwritew", {31'h0, RegWriteW}, 32'h0);
    check("rst2_aluoutw", ALUoutW, 32'h0);
    step();
    rst = 1'b0;
    mem_bus.mem_ready = 1'b1;
    nop();
    step();
`endif

    step(); step();
    check("beat_q_drained", beat_q.size(), 32'h0);
    check("wb_q_drained", wb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
